// File: rtl/mult_hilo_ctrl.sv
// HI/LO sequencer for a 16x16 unsigned multiplier: sign-magnitude conversion, fixed-latency wait, HI/LO writeback, MFHI/MFLO/MTHI/MTLO.
// HI/LO written MULT_LAT+1 edges after Start; Busy interlocks Start/Mt_We, and reads arriving while Busy complete with Done.
module mult_hilo_ctrl #(
  parameter int MULT_LAT = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Signed,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Mult_OpA,
  output logic [15:0] Mult_OpB,
  input  logic [31:0] Mult_Result,
  output logic        Busy,
  output logic        Done,
  input  logic        Mf_Req,
  input  logic        Mf_Sel,
  output logic [15:0] Mf_Data,
  output logic        Mf_Valid,
  input  logic        Mt_We,
  input  logic        Mt_Sel,
  input  logic [15:0] Mt_Data,
  output logic [15:0] HI,
  output logic [15:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WB} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] opa_q, opa_d, opb_q, opb_d;
  logic [15:0] hi_q, hi_d, lo_q, lo_d;
  logic [15:0] mf_data_q, mf_data_d;
  logic        mf_valid_q, mf_valid_d;
  logic        done_q, done_d;
  logic        neg_q, neg_d;
  logic        pend_q, pend_d;
  logic        pend_sel_q, pend_sel_d;
  logic [31:0] hilo;
  logic        wb_sel;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mf_data_q  <= '0;
      mf_valid_q <= 1'b0;
      done_q     <= 1'b0;
      neg_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mf_data_q  <= mf_data_d;
      mf_valid_q <= mf_valid_d;
      done_q     <= done_d;
      neg_q      <= neg_d;
      pend_q     <= pend_d;
      pend_sel_q <= pend_sel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mf_data_d  = mf_data_q;
    mf_valid_d = 1'b0;
    done_d     = 1'b0;
    neg_d      = neg_q;
    pend_d     = pend_q;
    pend_sel_d = pend_sel_q;
    hilo       = neg_q ? (~Mult_Result + 32'd1) : Mult_Result;
    wb_sel     = pend_q ? pend_sel_q : Mf_Sel;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          // -32768 negates to itself, which is the correct 16-bit magnitude
          opa_d   = (Signed && A[15]) ? (~A + 16'd1) : A;
          opb_d   = (Signed && B[15]) ? (~B + 16'd1) : B;
          neg_d   = Signed & (A[15] ^ B[15]);
          cnt_d   = MULT_LAT[3:0];
          state_d = S_WAIT;
        end else if (Mt_We) begin
          if (Mt_Sel) hi_d = Mt_Data;
          else        lo_d = Mt_Data;
        end
        if (Mf_Req) begin
          mf_data_d  = Mf_Sel ? hi_q : lo_q;
          mf_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_WB;
        if (Mf_Req && !pend_q) begin
          pend_d     = 1'b1;
          pend_sel_d = Mf_Sel;
        end
      end
      S_WB: begin
        hi_d    = hilo[31:16];
        lo_d    = hilo[15:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
        pend_d  = 1'b0;
        // A read arriving in the writeback cycle itself is served like a pending one
        if (pend_q || Mf_Req) begin
          mf_data_d  = wb_sel ? hilo[31:16] : hilo[15:0];
          mf_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Mult_OpA = opa_q;
  assign Mult_OpB = opb_q;
  assign Busy     = (state_q != S_IDLE);
  assign Done     = done_q;
  assign Mf_Data  = mf_data_q;
  assign Mf_Valid = mf_valid_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl with a MULT_LAT-deep pipelined multiplier model.
module tb_mult_hilo_ctrl;
  localparam int MULT_LAT = 2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start, Signed;
  logic [15:0] A, B;
  logic [15:0] Mult_OpA, Mult_OpB;
  logic [31:0] Mult_Result;
  logic        Busy, Done;
  logic        Mf_Req, Mf_Sel;
  logic [15:0] Mf_Data;
  logic        Mf_Valid;
  logic        Mt_We, Mt_Sel;
  logic [15:0] Mt_Data;
  logic [15:0] HI, LO;

  int n_chk  = 0;
  int n_fail = 0;

  mult_hilo_ctrl #(.MULT_LAT(MULT_LAT)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Signed(Signed), .A(A), .B(B),
    .Mult_OpA(Mult_OpA), .Mult_OpB(Mult_OpB), .Mult_Result(Mult_Result),
    .Busy(Busy), .Done(Done), .Mf_Req(Mf_Req), .Mf_Sel(Mf_Sel),
    .Mf_Data(Mf_Data), .Mf_Valid(Mf_Valid), .Mt_We(Mt_We), .Mt_Sel(Mt_Sel),
    .Mt_Data(Mt_Data), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  // Multiplier model: product valid MULT_LAT edges after operands settle
  logic [31:0] pipe [MULT_LAT];
  always @(posedge Clk) begin
    pipe[0] <= {16'd0, Mult_OpA} * {16'd0, Mult_OpB};
    for (int i = 1; i < MULT_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign Mult_Result = pipe[MULT_LAT-1];

  typedef struct {
    logic        sgn;
    logic [15:0] a, b, opa, opb, hi, lo;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic sgn, input logic [15:0] a, input logic [15:0] b);
    @(negedge Clk);
    Start = 1'b1; Signed = sgn; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  // Returns #1 after the edge at which Done rises; reports edges since Start
  task automatic wait_done(output int edges);
    edges = 0;
    while (!Done && edges < 20) begin
      @(posedge Clk); #1;
      edges++;
    end
  endtask

  task automatic run_mult(input vec_t v, input string tag);
    int e;
    issue(v.sgn, v.a, v.b);
    chk({tag, "_opa"}, Mult_OpA, v.opa);
    chk({tag, "_opb"}, Mult_OpB, v.opb);
    chk({tag, "_busy"}, Busy, 1'b1);
    wait_done(e);
    chk({tag, "_latency"}, e, MULT_LAT + 1);
    chk({tag, "_busy_end"}, Busy, 1'b0);
    chk({tag, "_hi"}, HI, v.hi);
    chk({tag, "_lo"}, LO, v.lo);
  endtask

  initial begin
    int e;
    vec_t v;
    vt[0] = '{1'b0, 16'd10,   16'd50,   16'd10,   16'd50,   16'h0000, 16'h01F4};
    vt[1] = '{1'b1, 16'hFFFD, 16'd5,    16'd3,    16'd5,    16'hFFFF, 16'hFFF1};
    vt[2] = '{1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h4000, 16'h0000};
    vt[3] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001};
    vt[4] = '{1'b1, 16'd7,    16'hFFFE, 16'd7,    16'd2,    16'hFFFF, 16'hFFF2};
    vt[5] = '{1'b1, 16'd0,    16'hFFFB, 16'd0,    16'd5,    16'h0000, 16'h0000};

    Rst = 1'b0; Start = 0; Signed = 0; A = 0; B = 0;
    Mf_Req = 0; Mf_Sel = 0; Mt_We = 0; Mt_Sel = 0; Mt_Data = 0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_hilo", {HI, LO}, 32'h0);
    chk("rst_ops", {Mult_OpA, Mult_OpB}, 32'h0);
    chk("rst_mf", {Mf_Valid, Mf_Data}, 17'h0);
    @(negedge Clk); Rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_mult(vt[i], $sformatf("vec%0d", i));
      @(posedge Clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), Done, 1'b0);
    end

    // Interlock: read pending while busy, ignored Start, dropped Mt_We
    issue(1'b0, 16'd10, 16'd50);
    @(negedge Clk);
    Mf_Req = 1; Mf_Sel = 0; Start = 1; A = 16'd99; B = 16'd1;
    Mt_We = 1; Mt_Sel = 1; Mt_Data = 16'hABCD;
    @(posedge Clk); #1;
    chk("il_valid_e1", Mf_Valid, 1'b0);
    chk("il_opa_hold", Mult_OpA, 16'd10);
    chk("il_hi_nowrite", HI, 16'h0000);
    @(negedge Clk);
    Mf_Req = 0; Start = 0; Mt_We = 0;
    @(posedge Clk); #1;
    chk("il_valid_e2", Mf_Valid, 1'b0);
    @(posedge Clk); #1;
    chk("il_done_e3", Done, 1'b1);
    chk("il_valid_e3", Mf_Valid, 1'b1);
    chk("il_data_e3", Mf_Data, 16'h01F4);
    chk("il_hi_e3", HI, 16'h0000);

    // Move ops with read-before-write
    @(negedge Clk);
    Mt_We = 1; Mt_Sel = 1; Mt_Data = 16'h1234; Mf_Req = 1; Mf_Sel = 1;
    @(posedge Clk); #1;
    chk("mv_rbw_valid", Mf_Valid, 1'b1);
    chk("mv_rbw_data", Mf_Data, 16'h0000);
    chk("mv_hi", HI, 16'h1234);
    @(negedge Clk);
    Mt_Sel = 0; Mt_Data = 16'h5678; Mf_Sel = 1;
    @(posedge Clk); #1;
    chk("mv_read_hi", Mf_Data, 16'h1234);
    chk("mv_lo", LO, 16'h5678);
    @(negedge Clk);
    Mt_We = 0; Mf_Sel = 0;
    @(posedge Clk); #1;
    chk("mv_read_lo", Mf_Data, 16'h5678);
    @(negedge Clk); Mf_Req = 0;
    @(posedge Clk); #1;
    chk("mv_valid_pulse", Mf_Valid, 1'b0);

    // Reset mid-operation
    issue(1'b0, 16'd7, 16'd9);
    @(negedge Clk); Mf_Req = 1; Mf_Sel = 1;
    @(posedge Clk); #2;
    Rst = 1'b0; Mf_Req = 0;
    #1;
    chk("mr_busy", Busy, 1'b0);
    chk("mr_hilo", {HI, LO}, 32'h0);
    chk("mr_opa", Mult_OpA, 16'h0);
    repeat (3) begin
      @(posedge Clk); #1;
      chk("mr_no_done", {Done, Mf_Valid}, 2'b00);
    end
    @(negedge Clk); Rst = 1'b1;
    repeat (3) begin
      @(posedge Clk); #1;
      chk("mr_quiet", {Done, Mf_Valid, Busy}, 3'b000);
    end
    v = '{1'b0, 16'd7, 16'd9, 16'd7, 16'd9, 16'h0000, 16'd63};
    run_mult(v, "mr_fresh");

    // Back-to-back: second Start lands in the Done cycle
    run_mult(vt[0], "b2b_first");
    v = '{1'b0, 16'd2, 16'd3, 16'd2, 16'd3, 16'h0000, 16'd6};
    run_mult(v, "b2b_second");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
Sequencer and HI/LO register file placed between instruction decode and the 16x16 unsigned Mult datapath. It accepts a multiply request and, for signed requests, converts the operands to magnitudes. It drives Mult's OpA/OpB and waits a fixed pipeline latency. It then captures Mult's 32-bit Result, sign-corrects it and writes it into HI/LO. It also serves MFHI/MFLO reads and MTHI/MTLO writes with a busy interlock.

Parameters:
MULT_LAT, 2, number of clock edges from Mult_OpA/Mult_OpB becoming stable to Mult_Result being valid; legal range 1..15.

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-low reset
Start  in  1  multiply request, sampled each rising edge
Signed  in  1  1 = signed (MULT), 0 = unsigned (MULTU); qualified by Start
A  in  16  operand A
B  in  16  operand B
Mult_OpA  out  16  operand to Mult (magnitude), registered
Mult_OpB  out  16  operand to Mult (magnitude), registered
Mult_Result  in  32  unsigned product from Mult
Busy  out  1  multiply in flight
Done  out  1  one-cycle pulse: HI/LO just written by a multiply
Mf_Req  in  1  read request
Mf_Sel  in  1  0 = LO, 1 = HI
Mf_Data  out  16  read data, registered
Mf_Valid  out  1  one-cycle pulse qualifying Mf_Data
Mt_We  in  1  write request
Mt_Sel  in  1  0 = LO, 1 = HI
Mt_Data  in  16  write data
HI  out  16  HI register
LO  out  16  LO register

Behaviour:
- Rst low (async) clears everything: state = IDLE; Mult_OpA, Mult_OpB, HI, LO, Mf_Data = 0; Busy, Done, Mf_Valid = 0; latency counter = 0; pending read cleared.
- FSM states are IDLE, WAIT and WB.
- IDLE, Start=1 at edge E0:
  - Mult_OpA = Signed ? |A| : A; Mult_OpB = Signed ? |B| : B. |-32768| = 0x8000.
  - Neg flag = Signed & (A[15] ^ B[15]).
  - Counter loaded with MULT_LAT; Busy = 1; go to WAIT.
- WAIT: counter decrements each edge. When it reaches 0 (edge E0+MULT_LAT), go to WB.
- WB, edge E0+MULT_LAT+1:
  - Mult_Result is sampled.
  - {HI,LO} = Neg ? two's-complement negation (~Result+1, 32 bits) : Result.
  - Busy = 0, Done = 1 for exactly one cycle; go to IDLE.
- Total latency: HI/LO are updated MULT_LAT+1 edges after the Start edge. Busy is high for exactly MULT_LAT+1 cycles.
- Mult_OpA/Mult_OpB hold their values until the next accepted Start. They are not cleared at WB.
- Start while Busy: ignored, no queuing. Decode must stall on Busy.
- Start in the same cycle as Done (first IDLE cycle): accepted normally.
- Mt_We:
  - In IDLE with Start=0: the selected register is written at that edge.
  - While Busy, or in the same cycle as an accepted Start: dropped (Start wins).
- Mf_Req:
  - Not Busy: Mf_Data = selected register value before the edge (read-before-write when Mt_We is in the same cycle); Mf_Valid = 1 for one cycle.
  - While Busy: request and Mf_Sel are latched as pending. At the WB edge, Mf_Data = the newly written HI or LO value and Mf_Valid pulses together with Done.
  - Further Mf_Req while a read is pending: ignored.
- Reset asserted mid-operation: aborts immediately. No Done pulse. HI/LO = 0. A pending read is dropped.

Test Plan:
- Reset, MULT_LAT=2. Unsigned: Start with A=10, B=50 at edge 0 -> Mult_OpA=10, Mult_OpB=50 after edge 0; Busy high 3 cycles; Done at edge 3; HI=0x0000, LO=0x01F4.
- Signed: A=0xFFFD (-3), B=5 -> Mult_OpA=3, Mult_OpB=5; Mult returns 15; HI=0xFFFF, LO=0xFFF1. Also A=B=0x8000 signed -> operands 0x8000/0x8000; HI=0x4000, LO=0x0000.
- Interlock: Mf_Req with Mf_Sel=0 one cycle after Start (A=10, B=50) -> Mf_Valid low until edge 3, then Mf_Data=0x01F4 with Mf_Valid and Done coincident. A Start issued at edge 1 is ignored and Mult_OpA stays 10.
- Move ops: in IDLE, Mt_We Mt_Sel=1 Mt_Data=0x1234 with Mf_Req Mf_Sel=1 the same cycle -> Mf_Data=old HI; the next read returns 0x1234. Mt_We while Busy -> HI/LO unchanged.
- Reset mid-op: Start (A=7, B=9), drive Rst low at edge 1 -> Busy=0, HI=LO=0, no Done. After release, a fresh Start completes normally (HI=0, LO=63).
- Back-to-back: Start again in the Done cycle with A=2, B=3 -> accepted; LO=6 at 3 edges later.
